// File: rtl/uart_rx_16x_pkg.sv
// rtl/uart_rx_16x_pkg.sv - shared lab4 serial constants and receiver FSM encoding
package uart_rx_16x_pkg;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE  = 3'd0;
    localparam rx_state_t ST_START = 3'd1;
    localparam rx_state_t ST_DATA  = 3'd2;
    localparam rx_state_t ST_STOP  = 3'd3;
    localparam rx_state_t ST_BREAK = 3'd4;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    localparam logic [3:0] SCNT_MID  = 4'(MID_SAMPLE);
    localparam logic [3:0] SCNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BCNT_LAST = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_rx_16x_if.sv
// rtl/uart_rx_16x_if.sv - received-byte holding register handshake to the datapath
interface uart_rx_16x_if;

    logic [7:0] rbr;
    logic       dataAvailable;
    logic       framingError;
    logic       overrun;
    logic       dataTaken;

    modport master (
        output rbr,
        output dataAvailable,
        output framingError,
        output overrun,
        input  dataTaken
    );

    modport slave (
        input  rbr,
        input  dataAvailable,
        input  framingError,
        input  overrun,
        output dataTaken
    );

endinterface

// File: rtl/uart_rx_16x_baud_tick_gen.sv
// rtl/uart_rx_16x_baud_tick_gen.sv - free-running 16x oversampling tick, shared with the transmitter
module baud_tick_gen #(
    parameter int DIVISOR = 326
) (
    input  logic CLK,
    input  logic RESETN,
    output logic tick
);

    localparam int            CW   = $clog2(DIVISOR);
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_16x.sv
// rtl/uart_rx_16x.sv - 8N1 serial receiver with 16x oversampling, holding register and status flags
module uart_rx_16x
    import uart_rx_16x_pkg::*;
#(
    parameter int DIVISOR = 326
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic            rxd,
    uart_rx_16x_if.master   rx_if
);

    logic       rxd_meta;
    logic       rxs;
    logic       tick;
    rx_state_t  state;
    logic [3:0] scnt;
    logic [2:0] bcnt;
    logic [7:0] shreg;
    logic       frame_ok;
    logic       frame_err;

    logic [7:0] rbr_q;
    logic       dav_q;
    logic       fe_q;
    logic       ov_q;

    baud_tick_gen #(.DIVISOR(DIVISOR)) u_tick (
        .CLK    (CLK),
        .RESETN (RESETN),
        .tick   (tick)
    );

    // Synchronizer flops reset high so a released reset never looks like a start bit edge.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxs      <= rxd_meta;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= ST_IDLE;
            scnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state <= ST_START;
                        scnt  <= '0;
                    end
                end
                ST_START: begin
                    if (scnt == SCNT_MID) begin
                        if (!rxs) begin
                            state <= ST_DATA;
                            scnt  <= '0;
                            bcnt  <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        scnt <= scnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    // scnt wraps 15 -> 0, so each later sample lands one full bit after the previous.
                    scnt <= scnt + 4'd1;
                    if (scnt == SCNT_LAST) begin
                        shreg <= {rxs, shreg[7:1]};
                        bcnt  <= bcnt + 3'd1;
                        if (bcnt == BCNT_LAST) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    scnt <= scnt + 4'd1;
                    if (scnt == SCNT_LAST) begin
                        state <= rxs ? ST_IDLE : ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (rxs) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign frame_ok  = tick && (state == ST_STOP) && (scnt == SCNT_LAST) &&  rxs;
    assign frame_err = tick && (state == ST_STOP) && (scnt == SCNT_LAST) && !rxs;

    // Acknowledge clears everything first; a same-cycle frame event then overrides its own flag.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            rbr_q <= '0;
            dav_q <= 1'b0;
            fe_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            if (rx_if.dataTaken) begin
                dav_q <= 1'b0;
                fe_q  <= 1'b0;
                ov_q  <= 1'b0;
            end
            if (frame_ok) begin
                if (!dav_q || rx_if.dataTaken) begin
                    rbr_q <= shreg;
                    dav_q <= 1'b1;
                    fe_q  <= 1'b0;
                end else begin
                    ov_q <= 1'b1;
                end
            end
            if (frame_err) begin
                fe_q <= 1'b1;
            end
        end
    end

    assign rx_if.rbr           = rbr_q;
    assign rx_if.dataAvailable = dav_q;
    assign rx_if.framingError  = fe_q;
    assign rx_if.overrun       = ov_q;

endmodule

// File: tb/tb_uart_rx_16x.sv
// tb/tb_uart_rx_16x.sv - directed table-driven bench for uart_rx_16x
module tb_uart_rx_16x;
    import uart_rx_16x_pkg::*;

    localparam int DIV      = 4;
    localparam int BIT_CLKS = 16 * DIV;
    localparam int GAP      = 16;

    typedef struct {
        logic       take;
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_rbr;
        logic       exp_dav;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    logic clk;
    logic resetn;
    logic rxd;
    int   n_checks;
    int   n_fail;
    logic found;
    vec_t vecs [6];

    uart_rx_16x_if rx_if ();

    uart_rx_16x #(.DIVISOR(DIV)) dut (
        .CLK    (clk),
        .RESETN (resetn),
        .rxd    (rxd),
        .rx_if  (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] r, input logic dav,
                             input logic fe, input logic ov);
        check8({name, ".rbr"}, rx_if.rbr, r);
        check1({name, ".dav"}, rx_if.dataAvailable, dav);
        check1({name, ".fe"}, rx_if.framingError, fe);
        check1({name, ".ov"}, rx_if.overrun, ov);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic pulse_take();
        rx_if.dataTaken = 1'b1;
        wait_clks(1);
        rx_if.dataTaken = 1'b0;
    endtask

    task automatic send_head(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
        rxd = 1'b1;
        if (gap > 0) wait_clks(gap);
        send_head(d);
        drive_bit(stop);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        found    = 1'b0;
        resetn   = 1'b0;
        rxd      = 1'b1;
        rx_if.dataTaken = 1'b0;

        vecs[0] = '{1'b0, 8'h55, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hA3, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h12, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h34, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'h3C, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'h81, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};

        wait_clks(3);
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        wait_clks(5);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].take) pulse_take();
            send_frame(vecs[v].data, vecs[v].stop, GAP);
            check_out($sformatf("vec%0d", v), vecs[v].exp_rbr, vecs[v].exp_dav,
                      vecs[v].exp_fe, vecs[v].exp_ov);
        end

        // Acknowledge drops dataAvailable on the very next edge.
        pulse_take();
        check1("take.dav", rx_if.dataAvailable, 1'b0);

        // Glitch shorter than half a bit must be rejected silently.
        rxd = 1'b0;
        wait_clks(4 * DIV);
        rxd = 1'b1;
        wait_clks(200);
        check8("glitch.state", dut.state, ST_IDLE);
        check_out("glitch", 8'h81, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b1, GAP);
        check_out("post_glitch", 8'hA3, 1'b1, 1'b0, 1'b0);

        // Low stop bit followed by a long break: one error, no phantom frame.
        pulse_take();
        send_frame(8'h3C, 1'b0, GAP);
        wait_clks(40 * DIV);
        rxd = 1'b1;
        wait_clks(200);
        check_out("break", 8'hA3, 1'b0, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, GAP);
        check_out("post_break", 8'h81, 1'b1, 1'b0, 1'b0);

        // Acknowledge lands in the exact cycle the back-to-back second frame completes.
        pulse_take();
        send_frame(8'h12, 1'b1, GAP);
        check_out("b2b_first", 8'h12, 1'b1, 1'b0, 1'b0);
        send_head(8'h34);
        rxd   = 1'b1;
        found = 1'b0;
        for (int i = 0; i < BIT_CLKS; i++) begin
            if (!found && dut.state == ST_STOP && dut.scnt == SCNT_LAST && dut.tick) begin
                rx_if.dataTaken = 1'b1;
                found = 1'b1;
            end
            wait_clks(1);
            rx_if.dataTaken = 1'b0;
        end
        check1("simul.found", found, 1'b1);
        check_out("simul", 8'h34, 1'b1, 1'b0, 1'b0);

        // Reset during data bit 4 of 0xF0 loses the frame.
        rxd = 1'b1;
        wait_clks(GAP);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rxd = 1'b1;
        wait_clks(BIT_CLKS / 2);
        resetn = 1'b0;
        wait_clks(3);
        check_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        wait_clks(BIT_CLKS / 2 - 3);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        wait_clks(200);
        check_out("after_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b1, GAP);
        check_out("post_reset", 8'h0F, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_16x.md
# uart_rx_16x

- Serial receive stage for the lab calculator: deserializes 8N1 frames from the `RXD` pin into bytes for the control/datapath.
- Generates its own 16x-oversampling tick from `CLK` and holds each received byte until the consumer acknowledges it.
- Reports framing errors and overruns.
- Sits between the `RXD` pin and the `dataIn`/`dataAvailable` inputs of the datapath.

## Interface
- `DIVISOR`, default 326: number of `CLK` cycles per 16x sample tick (9600 baud × 16 from the board clock); must be ≥ 2.
- `CLK` input 1: sole clock, rising edge.
- `RESETN` input 1: asynchronous, active-low reset.
- `rxd` input 1: raw serial line, asynchronous to `CLK`; idle high.
- `dataTaken` input 1: one-cycle acknowledge from the consumer; clears the status flags.
- `rbr` output 8: received byte, LSB received first.
- `dataAvailable` output 1: `rbr` holds an unacknowledged byte.
- `framingError` output 1: sticky; the last frame had a low stop bit.
- `overrun` output 1: sticky; a frame completed while `dataAvailable` was already 1.

## Operation
- **Synchronizer:** `rxd` passes through 2 flops, both reset to 1. All sampling uses the synchronized value `rxs`.
- **Tick generator:**
  - Counter runs 0..`DIVISOR`-1 and wraps.
  - `tick` = 1 for one `CLK` cycle when the count equals `DIVISOR`-1.
  - Runs freely and is never restarted.
- **Sample counter:** 4-bit `scnt`. Bit counter: 3-bit `bcnt`. Shift register: 8 bits, right-shifting, new bit enters at MSB.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. All transitions are evaluated only on `tick`.
  - IDLE: `rxs`=0 → START, `scnt`=0.
  - START: `scnt` increments. At `scnt`=7 (mid start bit): `rxs`=0 → DATA with `scnt`=0, `bcnt`=0; `rxs`=1 → IDLE (glitch rejected, no flag).
  - DATA: at `scnt`=15, shift in `rxs` and increment `bcnt`. When `bcnt` wraps from 7 → STOP.
  - STOP: at `scnt`=15 (mid stop bit):
    - `rxs`=1 → frame OK, IDLE.
    - `rxs`=0 → framing error, BREAK.
  - BREAK: remain until `rxs`=1 on a tick, then IDLE. A held-low line produces one error, not repeated frames.
- **Frame OK:**
  - `dataAvailable`=0, or `dataTaken`=1 in the same cycle: load `rbr`, set `dataAvailable`=1, clear `framingError`.
  - Otherwise: `rbr` unchanged, set `overrun`=1.
- **Framing error:** `rbr` unchanged, `dataAvailable` unchanged, `framingError`=1.
- **`dataTaken`=1:** clears `dataAvailable`, `overrun` and `framingError` on the next edge. A same-cycle frame-OK load or framing-error set takes precedence for its own flag.
- **`dataTaken` while `dataAvailable`=0:** no effect except clearing the sticky flags.

## Timing
- **Reset values:** `rbr`=0x00, `dataAvailable`=0, `framingError`=0, `overrun`=0, FSM=IDLE, all counters 0.
- **`RESETN` deasserted mid-frame:** the frame is lost. Reception restarts only at the next falling edge after `rxs` has been observed.
- **Input latency:** `rxd` → `rxs` is 2 `CLK` cycles.
- **Start detection:** quantized to tick boundaries, up to 1 tick of jitter.
- **Output latency:** `rbr`, `dataAvailable` and the flags update on the `CLK` edge after the tick that samples the stop bit. That is about 9.5 bit times (152 ticks) after the start-bit falling edge.
- **Data sampling:** each data bit is sampled 24 + 16·k ticks after start detection, k = 0..7 (start-bit centre + 1 bit).
- **Back-to-back frames:** a next start bit immediately after the stop bit is accepted; the FSM is in IDLE from mid stop bit onward.
- **Outputs:** all registered; no combinational path from `rxd` or `dataTaken` to any output.

## Structure
- **Shared package** (alongside the other lab4 constants):
  - FSM state encoding (3-bit localparams: IDLE, START, DATA, STOP, BREAK).
  - Frame constants: `DATA_BITS`=8, `OVERSAMPLE`=16, `MID_SAMPLE`=7.
- **Sub-module `baud_tick_gen`:** parameter `DIVISOR`; ports `CLK`, `RESETN`, `tick`. The transmitter reuses it.
- **Top level:** synchronizer, FSM, counters, shift register and holding register.
- **Size:** about 150–250 lines of RTL total.

## Test plan
- **Basic receive:** `DIVISOR`=4; send 0x55 as a clean 8N1 frame. Expect `rbr`=0x55 and `dataAvailable`=1 at stop-bit mid. Pulse `dataTaken` → `dataAvailable`=0 next cycle.
- **Glitch rejection:** drive `rxd` low for 4 ticks, then high. Expect the FSM to return to IDLE, `dataAvailable`=0 and no flags set. A following 0xA3 frame is received correctly.
- **Framing error:** send 0x3C with the stop bit low, hold the line low for 40 ticks, then high. Expect `framingError`=1, `dataAvailable`=0, `rbr` unchanged, and no second frame decoded. Then send 0x81 → `rbr`=0x81, `framingError`=0.
- **Overrun:** send 0x12 then 0x34 back-to-back without `dataTaken`. Expect `rbr`=0x12 and `overrun`=1; `dataTaken` clears both flags.
- **Simultaneous load and acknowledge:** assert `dataTaken` in the exact cycle the second frame (0x34) completes. Expect `rbr`=0x34, `dataAvailable`=1, `overrun`=0.
- **Reset mid-frame:** assert `RESETN`=0 during data bit 4 of 0xF0. Expect all outputs at reset values. A subsequent 0x0F frame is received correctly.
